// File: rtl/ext_clk_monitor.sv
// ext_clk_monitor
// Qualifies the external 10 MHz reference from the 250 MHz internal clock and
// produces the reference BUFGMUX select. The reference is measured by counting
// both edges of a divided-by-2 toggle over a fixed gate window. A run of good
// windows selects external, a run of bad windows drops back to internal, and a
// lost DCM lock or force_int falls back immediately.
module ext_clk_monitor #(
  parameter int GATE_CYCLES  = 25000,
  parameter int EXPECT_COUNT = 1000,
  parameter int TOLERANCE    = 2,
  parameter int LOCK_WINDOWS = 16,
  parameter int DROP_WINDOWS = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ext_toggle,
  input  logic                 ext_dcm_locked,
  input  logic                 force_int,
  output logic [CNT_WIDTH-1:0] freq_count,
  output logic                 freq_valid,
  output logic                 ext_good,
  output logic                 ext_clock_selected
);

  localparam int WIN_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam int BAD_W  = $clog2(DROP_WINDOWS + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(GATE_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_WINDOWS);
  localparam logic [BAD_W-1:0]  BAD_TARGET  = BAD_W'(DROP_WINDOWS);

  localparam logic [CNT_WIDTH:0] LOW_BOUND  = (EXPECT_COUNT > TOLERANCE) ?
                                              (CNT_WIDTH+1)'(EXPECT_COUNT - TOLERANCE) :
                                              (CNT_WIDTH+1)'(0);
  localparam logic [CNT_WIDTH:0] HIGH_BOUND = (CNT_WIDTH+1)'(EXPECT_COUNT + TOLERANCE);

  typedef enum logic [1:0] {
    ST_INT  = 2'd0,
    ST_QUAL = 2'd1,
    ST_EXT  = 2'd2
  } state_t;

  logic                 tog_s1, tog_s2, tog_s3;
  logic                 lock_s1, lock_s2;
  logic [WIN_W-1:0]     win_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic                 lock_lost;
  logic                 first_win;

  logic                 edge_det;
  logic                 win_last;
  logic [CNT_WIDTH-1:0] count_now;
  logic                 in_range;
  logic                 window_good;
  logic                 window_close;

  state_t               state_q, state_d;
  logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]     bad_cnt_q, bad_cnt_d;

  // Closing-window measurement: the terminal cycle folds in its own edge and its own lock sample.
  always_comb begin
    edge_det     = tog_s2 ^ tog_s3;
    win_last     = (win_cnt == WIN_LAST);
    count_now    = edge_cnt;
    if (edge_det && (edge_cnt != {CNT_WIDTH{1'b1}})) begin
      count_now = edge_cnt + CNT_WIDTH'(1);
    end
    in_range     = ({1'b0, count_now} >= LOW_BOUND) && ({1'b0, count_now} <= HIGH_BOUND);
    window_good  = in_range && !lock_lost && lock_s2;
    window_close = win_last && !first_win;
  end

  // Synchronizers for the two asynchronous inputs plus the edge-detect stage on the toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tog_s1  <= 1'b0;
      tog_s2  <= 1'b0;
      tog_s3  <= 1'b0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      tog_s1  <= ext_toggle;
      tog_s2  <= tog_s1;
      tog_s3  <= tog_s2;
      lock_s1 <= ext_dcm_locked;
      lock_s2 <= lock_s1;
    end
  end

  // Gate window, saturating edge counter, sticky lock-lost flag and the discard-first-window marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt   <= '0;
      edge_cnt  <= '0;
      lock_lost <= 1'b0;
      first_win <= 1'b1;
    end else if (win_last) begin
      win_cnt   <= '0;
      edge_cnt  <= '0;
      lock_lost <= 1'b0;
      first_win <= 1'b0;
    end else begin
      win_cnt  <= win_cnt + WIN_W'(1);
      edge_cnt <= count_now;
      if (!lock_s2) begin
        lock_lost <= 1'b1;
      end
    end
  end

  // Publish the result of each counted window; measurement continues even while overridden.
  always_ff @(posedge clk) begin
    if (rst) begin
      freq_count <= '0;
      freq_valid <= 1'b0;
      ext_good   <= 1'b0;
    end else begin
      freq_valid <= window_close;
      if (window_close) begin
        freq_count <= count_now;
        ext_good   <= window_good;
      end
    end
  end

  // Selection decision: overrides first, otherwise hysteresis on counted window results.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (force_int || (!lock_s2 && (state_q != ST_INT))) begin
      state_d    = ST_INT;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else if (window_close) begin
      case (state_q)
        ST_INT: begin
          if (window_good) begin
            bad_cnt_d = '0;
            if (GOOD_TARGET == GOOD_W'(1)) begin
              state_d    = ST_EXT;
              good_cnt_d = '0;
            end else begin
              state_d    = ST_QUAL;
              good_cnt_d = GOOD_W'(1);
            end
          end
        end
        ST_QUAL: begin
          if (!window_good) begin
            state_d    = ST_INT;
            good_cnt_d = '0;
          end else if ((good_cnt_q + GOOD_W'(1)) == GOOD_TARGET) begin
            state_d    = ST_EXT;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
          end
        end
        ST_EXT: begin
          if (window_good) begin
            bad_cnt_d = '0;
          end else if ((bad_cnt_q + BAD_W'(1)) == BAD_TARGET) begin
            state_d   = ST_INT;
            bad_cnt_d = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + BAD_W'(1);
          end
        end
        default: begin
          state_d    = ST_INT;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
        end
      endcase
    end
  end

  // State register; the select output is registered from the next state so it moves with freq_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_INT;
      good_cnt_q         <= '0;
      bad_cnt_q          <= '0;
      ext_clock_selected <= 1'b0;
    end else begin
      state_q            <= state_d;
      good_cnt_q         <= good_cnt_d;
      bad_cnt_q          <= bad_cnt_d;
      ext_clock_selected <= (state_d == ST_EXT);
    end
  end

endmodule

// File: tb/tb_ext_clk_monitor.sv
// tb_ext_clk_monitor
// Directed window-by-window stimulus for ext_clk_monitor with a shortened gate
// window. Each window's expected report is queued when the window starts and a
// separate monitor pops and compares it whenever freq_valid is seen.
module tb_ext_clk_monitor;

  localparam int GATE       = 500;
  localparam int EXPECT     = 20;
  localparam int TOL        = 2;
  localparam int LOCK_WIN   = 4;
  localparam int DROP_WIN   = 2;
  localparam int CW         = 16;
  localparam int EDGE_START = 10;
  localparam int EDGE_END   = GATE - 10;
  localparam int MID        = 250;

  localparam int EVT_NONE       = 0;
  localparam int EVT_LOCK_DROP  = 1;
  localparam int EVT_FORCE_PULSE = 2;
  localparam int EVT_FORCE_HOLD = 3;
  localparam int EVT_RESET      = 4;

  typedef struct packed {
    logic [15:0] period;
    logic        lock;
    logic [2:0]  evt;
    logic        push;
    logic [15:0] cnt;
    logic        good;
    logic        sel;
  } row_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic        good;
    logic        sel;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ext_toggle;
  logic          ext_dcm_locked;
  logic          force_int;
  logic [CW-1:0] freq_count;
  logic          freq_valid;
  logic          ext_good;
  logic          ext_clock_selected;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   period       = 0;
  int   pos          = 0;
  int   cyc          = 0;
  int   last_valid   = -1;
  exp_t exp_q[$];
  row_t rows[$];

  ext_clk_monitor #(
    .GATE_CYCLES  (GATE),
    .EXPECT_COUNT (EXPECT),
    .TOLERANCE    (TOL),
    .LOCK_WINDOWS (LOCK_WIN),
    .DROP_WINDOWS (DROP_WIN),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ext_toggle         (ext_toggle),
    .ext_dcm_locked     (ext_dcm_locked),
    .force_int          (force_int),
    .freq_count         (freq_count),
    .freq_valid         (freq_valid),
    .ext_good           (ext_good),
    .ext_clock_selected (ext_clock_selected)
  );

  always #2 clk = ~clk;

  // Bench copy of the window position, used only to place stimulus inside a window.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || (pos == GATE - 1)) pos <= 0;
    else pos <= pos + 1;
  end

  // Reference toggle: edges at fixed window offsets so each window holds a known edge count.
  initial begin
    ext_toggle = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if ((period > 0) && (pos >= EDGE_START) && (pos <= EDGE_END) &&
          (((pos - EDGE_START) % period) == 0)) begin
        ext_toggle = ~ext_toggle;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((pos != target) && (n < GATE + 4));
    if (pos != target) checkOutput("wait_pos_timeout", pos, target);
  endtask

  task automatic add_row(input int p, input bit lk, input int evt, input bit push,
                         input int cnt, input bit good, input bit sel);
    row_t r;
    r.period = 16'(p);
    r.lock   = lk;
    r.evt    = 3'(evt);
    r.push   = push;
    r.cnt    = 16'(cnt);
    r.good   = good;
    r.sel    = sel;
    rows.push_back(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_freq_count"}, freq_count, 0);
    checkOutput({tag, "_freq_valid"}, freq_valid, 0);
    checkOutput({tag, "_ext_good"}, ext_good, 0);
    checkOutput({tag, "_ext_sel"}, ext_clock_selected, 0);
  endtask

  task automatic applyStimulus(input row_t r);
    exp_t e;
    wait_pos(0);
    period         = int'(r.period);
    ext_dcm_locked = r.lock;
    if (r.push) begin
      e.cnt  = r.cnt;
      e.good = r.good;
      e.sel  = r.sel;
      exp_q.push_back(e);
    end
    case (int'(r.evt))
      EVT_LOCK_DROP: begin
        wait_pos(MID);
        checkOutput("sel_before_lock_drop", ext_clock_selected, 1);
        ext_dcm_locked = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("sel_after_lock_drop", ext_clock_selected, 0);
        wait_pos(400);
        ext_dcm_locked = 1'b1;
      end
      EVT_FORCE_PULSE: begin
        wait_pos(MID);
        force_int = 1'b1;
        @(posedge clk);
        #1;
        force_int = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("sel_after_force_pulse", ext_clock_selected, 0);
      end
      EVT_FORCE_HOLD: begin
        wait_pos(MID);
        checkOutput("sel_before_force", ext_clock_selected, 1);
        force_int = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sel_after_force", ext_clock_selected, 0);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("sel_during_force", ext_clock_selected, 0);
        force_int = 1'b0;
      end
      EVT_RESET: begin
        wait_pos(MID);
        checkOutput("sel_before_reset", ext_clock_selected, 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("mid_reset");
      end
      default: ;
    endcase
  endtask

  // Monitor: every freq_valid must match the oldest queued window and keep the window cadence.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_valid = -1;
    end else if (freq_valid) begin
      if (last_valid >= 0) checkOutput("valid_period", cyc - last_valid, GATE);
      last_valid = cyc;
      checkOutput("expect_queue_nonempty", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("freq_count", freq_count, e.cnt);
        checkOutput("ext_good", ext_good, e.good);
        checkOutput("ext_sel", ext_clock_selected, e.sel);
      end
    end
  end

  initial begin
    int n;
    rst            = 1'b1;
    ext_dcm_locked = 1'b0;
    force_int      = 1'b0;
    period         = 0;

    add_row( 0, 0, EVT_NONE, 1,  0, 0, 0);
    add_row( 0, 0, EVT_NONE, 1,  0, 0, 0);
    add_row( 0, 1, EVT_NONE, 1,  0, 0, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 1);
    add_row(20, 1, EVT_NONE, 1, 25, 0, 1);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 1);
    add_row(20, 1, EVT_NONE, 1, 25, 0, 1);
    add_row(24, 1, EVT_NONE, 1, 21, 1, 1);
    add_row(20, 1, EVT_NONE, 1, 25, 0, 1);
    add_row(20, 1, EVT_NONE, 1, 25, 0, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 1);
    add_row(25, 1, EVT_LOCK_DROP, 1, 20, 0, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_FORCE_PULSE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 1);
    add_row(25, 1, EVT_FORCE_HOLD, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 1);
    add_row(25, 1, EVT_RESET, 0,  0, 0, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 0);
    add_row(25, 1, EVT_NONE, 1, 20, 1, 1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    foreach (rows[i]) applyStimulus(rows[i]);

    n = 0;
    while ((exp_q.size() != 0) && (n < 2 * GATE)) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("pending_expectations", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
